// File: rtl/sim_sdram_model_if.sv
// CPU, video and tape port bundle for the simulated SDRAM model.
// master = core side, slave = memory model side.
interface sim_sdram_model_if;
    logic [22:0] addr;
    logic [1:0]  bank;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        oe;
    logic        we;
    logic [22:0] vram_addr;
    logic [15:0] vram_dout;
    logic [22:0] tape_addr;
    logic [7:0]  tape_din;
    logic [7:0]  tape_dout;
    logic        tape_wr;
    logic        tape_wr_ack;
    logic        tape_rd;
    logic        tape_rd_ack;

    modport master (
        output addr, bank, din, oe, we,
        output vram_addr,
        output tape_addr, tape_din,
        output tape_wr, tape_rd,
        input  dout, vram_dout, tape_dout,
        input  tape_wr_ack, tape_rd_ack
    );

    modport slave (
        input  addr, bank, din, oe, we,
        input  vram_addr,
        input  tape_addr, tape_din,
        input  tape_wr, tape_rd,
        output dout, vram_dout, tape_dout,
        output tape_wr_ack, tape_rd_ack
    );
endinterface

// File: rtl/sim_sdram_model.sv
// Behavioural SDRAM stand-in: CPU, video and tape ports on one byte array.
// Array starts zero-filled.
module sim_sdram_model #(
    parameter int    MEM_AW    = 23,
    parameter string INIT_FILE = "sdram.hex"
) (
    input  logic        clk,
    input  logic        init,
    input  logic        clkref,
    sim_sdram_model_if.slave bus,
    inout  wire  [15:0] SDRAM_DQ,
    output logic [12:0] SDRAM_A,
    output logic [1:0]  SDRAM_BA,
    output logic        SDRAM_DQML,
    output logic        SDRAM_DQMH,
    output logic        SDRAM_nCS,
    output logic        SDRAM_nWE,
    output logic        SDRAM_nRAS,
    output logic        SDRAM_nCAS,
    output logic        SDRAM_CLK,
    output logic        SDRAM_CKE
);
    localparam int DEPTH = 1 << MEM_AW;

    logic [7:0] mem [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++)
            mem[i] = 8'h00;
    end

    logic [MEM_AW-1:0] cpu_a;
    logic [MEM_AW-1:0] vid_lo;
    logic [MEM_AW-1:0] vid_hi;
    logic [MEM_AW-1:0] tape_a;

    logic [7:0]  dout_q;
    logic [15:0] vid_q;
    logic [7:0]  tdout_q;
    logic        wr_ack_q;
    logic        rd_ack_q;

    logic wr_pend;
    logic rd_pend;
    logic tape_slot;
    logic tape_wr_go;

    assign cpu_a  = bus.addr[MEM_AW-1:0];
    assign tape_a = bus.tape_addr[MEM_AW-1:0];
    assign vid_lo = {bus.vram_addr[MEM_AW-1:1], 1'b0};
    assign vid_hi = {bus.vram_addr[MEM_AW-1:1], 1'b1};

    assign wr_pend    = bus.tape_wr != wr_ack_q;
    assign rd_pend    = bus.tape_rd != rd_ack_q;
    // CPU owns the slot when it writes; tape waits for the next one.
    assign tape_slot  = clkref & ~bus.we & ~init;
    assign tape_wr_go = tape_slot & wr_pend;

    // Array has no reset so downloads survive init.
    always_ff @(posedge clk) begin
        if (bus.we)
            mem[cpu_a] <= bus.din;
        else if (tape_wr_go)
            mem[tape_a] <= bus.tape_din;
    end

    always_ff @(posedge clk) begin
        if (init) begin
            dout_q   <= 8'hFF;
            vid_q    <= 16'hFFFF;
            tdout_q  <= 8'h00;
            wr_ack_q <= 1'b0;
            rd_ack_q <= 1'b0;
        end else begin
            if (bus.we)
                dout_q <= bus.din;
            else if (bus.oe)
                dout_q <= mem[cpu_a];

            if (clkref)
                vid_q <= {mem[vid_hi], mem[vid_lo]};

            if (tape_slot) begin
                if (wr_pend) begin
                    wr_ack_q <= bus.tape_wr;
                end else if (rd_pend) begin
                    tdout_q  <= mem[tape_a];
                    rd_ack_q <= bus.tape_rd;
                end
            end
        end
    end

    assign bus.dout        = dout_q;
    assign bus.vram_dout   = vid_q;
    assign bus.tape_dout   = tdout_q;
    assign bus.tape_wr_ack = wr_ack_q;
    assign bus.tape_rd_ack = rd_ack_q;

    assign SDRAM_DQ   = 16'hzzzz;
    assign SDRAM_A    = '0;
    assign SDRAM_BA   = '0;
    assign SDRAM_DQML = 1'b1;
    assign SDRAM_DQMH = 1'b1;
    assign SDRAM_nCS  = 1'b1;
    assign SDRAM_nWE  = 1'b1;
    assign SDRAM_nRAS = 1'b1;
    assign SDRAM_nCAS = 1'b1;
    assign SDRAM_CLK  = 1'b0;
    assign SDRAM_CKE  = 1'b0;

    logic unused;
    assign unused = ^{bus.bank, SDRAM_DQ, bus.addr,
                      bus.vram_addr, bus.tape_addr};
endmodule

// File: tb/tb_sim_sdram_model.sv
// Bench for sim_sdram_model: directed cases plus random traffic
// compared against a transaction-level memory model.
module tb_sim_sdram_model;
    logic clk = 1'b0;
    logic init;
    logic clkref;

    sim_sdram_model_if bus();

    wire  [15:0] sd_dq;
    logic [12:0] sd_a;
    logic [1:0]  sd_ba;
    logic sd_dqml, sd_dqmh, sd_ncs, sd_nwe;
    logic sd_nras, sd_ncas, sd_clk, sd_cke;

    sim_sdram_model dut (
        .clk        (clk),
        .init       (init),
        .clkref     (clkref),
        .bus        (bus),
        .SDRAM_DQ   (sd_dq),
        .SDRAM_A    (sd_a),
        .SDRAM_BA   (sd_ba),
        .SDRAM_DQML (sd_dqml),
        .SDRAM_DQMH (sd_dqmh),
        .SDRAM_nCS  (sd_ncs),
        .SDRAM_nWE  (sd_nwe),
        .SDRAM_nRAS (sd_nras),
        .SDRAM_nCAS (sd_ncas),
        .SDRAM_CLK  (sd_clk),
        .SDRAM_CKE  (sd_cke)
    );

    always #10 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference state
    logic [7:0]  ref_mem [int];
    logic [7:0]  m_dout;
    logic [15:0] m_vid;
    logic [7:0]  m_tdout;
    logic        m_wack;
    logic        m_rack;
    logic        last_slot;

    task automatic chk(string tag, logic [31:0] got,
                       logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rd(logic [22:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
    endfunction

    // One clock; reference advances on the inputs seen at the edge.
    task automatic tick();
        logic        i_init, i_ref, i_we, i_oe;
        logic        i_twr, i_trd;
        logic [22:0] i_a, i_va, i_ta;
        logic [7:0]  i_d, i_td;
        logic        tw;
        i_init = init;   i_ref = clkref;
        i_we = bus.we;   i_oe = bus.oe;
        i_a = bus.addr;  i_d = bus.din;
        i_va = bus.vram_addr;
        i_ta = bus.tape_addr; i_td = bus.tape_din;
        i_twr = bus.tape_wr;  i_trd = bus.tape_rd;
        tw = 1'b0;
        @(posedge clk);
        #1;
        last_slot = i_ref;
        if (i_init) begin
            m_dout = 8'hFF; m_vid = 16'hFFFF;
            m_tdout = 8'h00; m_wack = 0; m_rack = 0;
        end else begin
            if (i_we)      m_dout = i_d;
            else if (i_oe) m_dout = rd(i_a);
            if (i_ref)
                m_vid = {rd({i_va[22:1], 1'b1}),
                         rd({i_va[22:1], 1'b0})};
            if (i_ref && !i_we) begin
                if (i_twr != m_wack) begin
                    tw = 1'b1; m_wack = i_twr;
                end else if (i_trd != m_rack) begin
                    m_tdout = rd(i_ta); m_rack = i_trd;
                end
            end
        end
        if (i_we) ref_mem[int'(i_a)] = i_d;
        if (tw)   ref_mem[int'(i_ta)] = i_td;
        chk("dout", {24'd0, bus.dout}, {24'd0, m_dout});
        chk("vram_dout", {16'd0, bus.vram_dout}, {16'd0, m_vid});
        chk("tape_dout", {24'd0, bus.tape_dout}, {24'd0, m_tdout});
        chk("wr_ack", {31'd0, bus.tape_wr_ack}, {31'd0, m_wack});
        chk("rd_ack", {31'd0, bus.tape_rd_ack}, {31'd0, m_rack});
        cyc++;
        clkref = (cyc % 8 == 7);
    endtask

    task automatic idle_in();
        bus.we = 0; bus.oe = 0;
    endtask

    localparam logic [22:0] POOL = 23'h41C000;

    initial begin
        int n;
        bit hit;
        init = 1; clkref = 0;
        bus.addr = 0; bus.bank = 0; bus.din = 0;
        bus.oe = 0; bus.we = 0; bus.vram_addr = 0;
        bus.tape_addr = 0; bus.tape_din = 0;
        bus.tape_wr = 0; bus.tape_rd = 0;
        m_dout = 0; m_vid = 0; m_tdout = 0;
        m_wack = 0; m_rack = 0; last_slot = 0;

        repeat (3) tick();
        chk("rst_dout", {24'd0, bus.dout}, 32'hFF);
        chk("rst_vram", {16'd0, bus.vram_dout}, 32'hFFFF);
        chk("rst_tdout", {24'd0, bus.tape_dout}, 32'h00);
        chk("pin_idle", {22'd0, sd_a, sd_ba, sd_cke, sd_clk},
            32'd0);
        chk("pin_high", {26'd0, sd_ncs, sd_nwe, sd_nras, sd_ncas,
            sd_dqml, sd_dqmh}, 32'h3F);

        // write while init held
        bus.we = 1; bus.addr = 23'h000123; bus.din = 8'hA5;
        tick();
        idle_in();
        tick();
        chk("init_wr_dout", {24'd0, bus.dout}, 32'hFF);
        init = 0;
        tick();
        bus.oe = 1; bus.addr = 23'h000123;
        tick();
        chk("dl_read", {24'd0, bus.dout}, 32'hA5);
        idle_in();

        // seed the random pool so every pool read is defined
        for (int i = 0; i < 64; i++) begin
            bus.we = 1; bus.addr = POOL + 23'(i);
            bus.din = 8'($urandom);
            tick();
        end
        idle_in();

        // video word
        bus.we = 1; bus.addr = POOL; bus.din = 8'h3C; tick();
        bus.addr = POOL + 1; bus.din = 8'hC3; tick();
        idle_in();
        bus.vram_addr = POOL;
        n = 0; hit = 0;
        while (!hit && n < 20) begin
            tick(); n++; hit = last_slot;
        end
        chk("vid_slot_seen", {31'd0, hit}, 32'd1);
        chk("vid_word", {16'd0, bus.vram_dout}, 32'hC33C);
        bus.vram_addr = POOL + 1;
        n = 0; hit = 0;
        while (!hit && n < 20) begin
            tick(); n++; hit = last_slot;
        end
        chk("vid_odd", {16'd0, bus.vram_dout}, 32'hC33C);

        // tape write
        bus.tape_addr = 23'h010000; bus.tape_din = 8'h5A;
        bus.tape_wr = 1;
        n = 0; hit = 0;
        while (!hit && n < 20) begin
            tick(); n++; hit = bus.tape_wr_ack;
        end
        chk("twr_ack", {31'd0, bus.tape_wr_ack}, 32'd1);
        chk("twr_on_slot", {31'd0, last_slot}, 32'd1);

        // tape read deferred by CPU write in the slot
        while (clkref) tick();
        bus.we = 1; bus.addr = POOL + 23'h20; bus.din = 8'h11;
        bus.tape_rd = 1;
        n = 0; hit = 0;
        while (!hit && n < 20) begin
            tick(); n++; hit = last_slot;
        end
        chk("trd_deferred", {31'd0, bus.tape_rd_ack}, 32'd0);
        idle_in();
        n = 0; hit = 0;
        while (!hit && n < 20) begin
            tick(); n++; hit = bus.tape_rd_ack;
        end
        chk("trd_ack", {31'd0, bus.tape_rd_ack}, 32'd1);
        chk("trd_data", {24'd0, bus.tape_dout}, 32'h5A);

        // we has priority over oe
        bus.we = 1; bus.oe = 1; bus.addr = 23'h000010;
        bus.din = 8'h77;
        tick();
        chk("we_prio", {24'd0, bus.dout}, 32'h77);
        bus.we = 0; bus.din = 8'h00;
        tick();
        chk("we_prio_mem", {24'd0, bus.dout}, 32'h77);
        idle_in();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.we = ($urandom_range(3) == 0);
            bus.oe = ($urandom_range(1) == 0);
            bus.addr = POOL + 23'($urandom_range(63));
            bus.din = 8'($urandom);
            if ($urandom_range(7) == 0)
                bus.vram_addr = POOL + 23'($urandom_range(63));
            if (bus.tape_wr == bus.tape_wr_ack &&
                bus.tape_rd == bus.tape_rd_ack) begin
                bus.tape_addr = POOL + 23'($urandom_range(63));
                bus.tape_din = 8'($urandom);
                if ($urandom_range(3) == 0)
                    bus.tape_wr = ~bus.tape_wr;
                else if ($urandom_range(2) == 0)
                    bus.tape_rd = ~bus.tape_rd;
            end
            init = ($urandom_range(99) == 0);
            tick();
        end
        init = 0;
        idle_in();
        tick();

        // init with tape read pending
        bus.tape_addr = 23'h010000;
        bus.tape_rd = ~bus.tape_rd;
        init = 1;
        repeat (10) tick();
        chk("mid_dout", {24'd0, bus.dout}, 32'hFF);
        chk("mid_vram", {16'd0, bus.vram_dout}, 32'hFFFF);
        chk("mid_wack", {31'd0, bus.tape_wr_ack}, 32'd0);
        chk("mid_rack", {31'd0, bus.tape_rd_ack}, 32'd0);
        init = 0;
        bus.oe = 1; bus.addr = 23'h000123;
        tick();
        chk("keep_a5", {24'd0, bus.dout}, 32'hA5);
        bus.addr = 23'h010000;
        tick();
        chk("keep_5a", {24'd0, bus.dout}, 32'h5A);
        bus.addr = 23'h000010;
        tick();
        chk("keep_77", {24'd0, bus.dout}, 32'h77);
        idle_in();
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
